// File: rtl/pipe_hzd_ctrl.sv
// Decode-stage hazard and redirect controller: load scoreboard with RAW/WAW/full
// stalls, plus a squash FSM that turns wrong-path fetches into NOPs after a redirect.
module pipe_hzd_ctrl #(
   parameter int unsigned NOP_SLOTS = 2,
   parameter int unsigned MAX_LD    = 4,
   localparam int unsigned REG_ADDRW = 5
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_idu_valid,
   input  logic                 i_idu_fire,
   input  logic [REG_ADDRW-1:0] i_idu_rs1id,
   input  logic [REG_ADDRW-1:0] i_idu_rs2id,
   input  logic [REG_ADDRW-1:0] i_idu_rdid,
   input  logic                 i_idu_rdwen,
   input  logic                 i_idu_lden,
   input  logic                 i_ld_ret,
   input  logic [REG_ADDRW-1:0] i_ld_retid,
   input  logic                 i_redirect,
   input  logic                 i_ifu_fire,
   output logic                 o_idu_stall,
   output logic                 o_ifu_nop,
   output logic                 o_ld_full,
   output logic [31:0]          o_pend_mask,
   output logic [31:0]          s_stall_cnt
);

   localparam logic [3:0] LD_MAX_C = 4'(MAX_LD);
   localparam logic [3:0] NOP_C    = 4'(NOP_SLOTS);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_SQUASH = 1'b1
   } state_t;

   function automatic logic [31:0] onehot(input logic [REG_ADDRW-1:0] idx);
      onehot = 32'd1 << idx;
   endfunction

   logic [31:0] r_pend;
   logic [3:0]  r_ld_cnt;
   logic        r_ld_full;
   logic [31:0] r_stall_cnt;
   state_t      r_state;
   logic [3:0]  r_sq_cnt;
   logic        r_nop;

   logic        w_ld_issue;
   logic        w_sb_set;
   logic [31:0] w_set_vec;
   logic [31:0] w_clr_vec;
   logic [31:0] w_eff;
   logic [31:0] w_pend_nxt;
   logic        w_raw;
   logic        w_waw;
   logic        w_full;
   logic        w_stall;
   logic        w_ld_inc;
   logic        w_ld_dec;
   logic [3:0]  w_ld_cnt_nxt;

   assign w_ld_issue = i_idu_fire & i_idu_lden;
   assign w_sb_set   = w_ld_issue & i_idu_rdwen & (i_idu_rdid != 5'd0);

   // Scoreboard set/clear vectors
   always_comb begin
      w_set_vec = 32'd0;
      w_clr_vec = 32'd0;
      if (w_sb_set) begin
         w_set_vec = onehot(i_idu_rdid);
      end else begin
         w_set_vec = 32'd0;
      end
      if (i_ld_ret) begin
         w_clr_vec = onehot(i_ld_retid);
      end else begin
         w_clr_vec = 32'd0;
      end
   end

   // A returning load releases its hazard in the same cycle; a same-cycle reissue wins.
   assign w_eff      = r_pend & ~w_clr_vec;
   assign w_pend_nxt = (w_eff | w_set_vec) & 32'hFFFF_FFFE;

   assign w_raw   = ((i_idu_rs1id != 5'd0) & w_eff[i_idu_rs1id]) |
                    ((i_idu_rs2id != 5'd0) & w_eff[i_idu_rs2id]);
   assign w_waw   = i_idu_rdwen & (i_idu_rdid != 5'd0) & w_eff[i_idu_rdid];
   assign w_full  = i_idu_lden & (r_ld_cnt == LD_MAX_C) & ~i_ld_ret;
   assign w_stall = i_idu_valid & (w_raw | w_waw | w_full);

   // Outstanding-load count next state; never wraps in either direction
   always_comb begin
      w_ld_dec     = i_ld_ret & (r_ld_cnt != 4'd0);
      w_ld_inc     = w_ld_issue & ((r_ld_cnt != LD_MAX_C) | w_ld_dec);
      w_ld_cnt_nxt = r_ld_cnt;
      case ({w_ld_inc, w_ld_dec})
         2'b10:   w_ld_cnt_nxt = r_ld_cnt + 4'd1;
         2'b01:   w_ld_cnt_nxt = r_ld_cnt - 4'd1;
         default: w_ld_cnt_nxt = r_ld_cnt;
      endcase
   end

   // Scoreboard, load counter and full flag
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pend    <= 32'd0;
         r_ld_cnt  <= 4'd0;
         r_ld_full <= 1'b0;
      end else begin
         r_pend    <= w_pend_nxt;
         r_ld_cnt  <= w_ld_cnt_nxt;
         r_ld_full <= (w_ld_cnt_nxt == LD_MAX_C);
      end
   end

   // Redirect squash FSM; a redirect while squashing restarts the slot count
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_IDLE;
         r_sq_cnt <= 4'd0;
         r_nop    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_redirect) begin
                  r_state  <= ST_SQUASH;
                  r_sq_cnt <= NOP_C;
                  r_nop    <= 1'b1;
               end else begin
                  r_state  <= ST_IDLE;
                  r_sq_cnt <= 4'd0;
                  r_nop    <= 1'b0;
               end
            end
            ST_SQUASH: begin
               if (i_redirect) begin
                  r_sq_cnt <= NOP_C;
                  r_nop    <= 1'b1;
               end else if (i_ifu_fire) begin
                  if (r_sq_cnt <= 4'd1) begin
                     r_state  <= ST_IDLE;
                     r_sq_cnt <= 4'd0;
                     r_nop    <= 1'b0;
                  end else begin
                     r_sq_cnt <= r_sq_cnt - 4'd1;
                     r_nop    <= 1'b1;
                  end
               end else begin
                  r_nop <= 1'b1;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_sq_cnt <= 4'd0;
               r_nop    <= 1'b0;
            end
         endcase
      end
   end

   // Saturating stall-cycle counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_cnt <= 32'd0;
      end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end else begin
         r_stall_cnt <= r_stall_cnt;
      end
   end

   assign o_idu_stall = w_stall;
   assign o_ifu_nop   = r_nop;
   assign o_ld_full   = r_ld_full;
   assign o_pend_mask = r_pend;
   assign s_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hzd_ctrl.sv
// Directed bench for pipe_hzd_ctrl: expectations are queued when a step is driven
// and checked against the DUT outputs at the following falling edge.
module tb_pipe_hzd_ctrl;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_idu_valid;
   logic        i_idu_fire;
   logic [4:0]  i_idu_rs1id;
   logic [4:0]  i_idu_rs2id;
   logic [4:0]  i_idu_rdid;
   logic        i_idu_rdwen;
   logic        i_idu_lden;
   logic        i_ld_ret;
   logic [4:0]  i_ld_retid;
   logic        i_redirect;
   logic        i_ifu_fire;
   logic        o_idu_stall;
   logic        o_ifu_nop;
   logic        o_ld_full;
   logic [31:0] o_pend_mask;
   logic [31:0] s_stall_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int exp_sc = 0;

   string       tq[$];
   int          sq[$];
   logic [31:0] eq[$];

   localparam int SEL_STALL = 0;
   localparam int SEL_NOP   = 1;
   localparam int SEL_FULL  = 2;
   localparam int SEL_PEND  = 3;
   localparam int SEL_SCNT  = 4;

   pipe_hzd_ctrl #(.NOP_SLOTS(2), .MAX_LD(4)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_idu_valid (i_idu_valid),
      .i_idu_fire  (i_idu_fire),
      .i_idu_rs1id (i_idu_rs1id),
      .i_idu_rs2id (i_idu_rs2id),
      .i_idu_rdid  (i_idu_rdid),
      .i_idu_rdwen (i_idu_rdwen),
      .i_idu_lden  (i_idu_lden),
      .i_ld_ret    (i_ld_ret),
      .i_ld_retid  (i_ld_retid),
      .i_redirect  (i_redirect),
      .i_ifu_fire  (i_ifu_fire),
      .o_idu_stall (o_idu_stall),
      .o_ifu_nop   (o_ifu_nop),
      .o_ld_full   (o_ld_full),
      .o_pend_mask (o_pend_mask),
      .s_stall_cnt (s_stall_cnt)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   function automatic logic [31:0] obs(input int sel);
      case (sel)
         SEL_STALL: obs = {31'd0, o_idu_stall};
         SEL_NOP:   obs = {31'd0, o_ifu_nop};
         SEL_FULL:  obs = {31'd0, o_ld_full};
         SEL_PEND:  obs = o_pend_mask;
         SEL_SCNT:  obs = s_stall_cnt;
         default:   obs = 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic push(input string t, input int s, input logic [31:0] e);
      tq.push_back(t);
      sq.push_back(s);
      eq.push_back(e);
   endtask

   task automatic drain();
      string       t;
      int          s;
      logic [31:0] e;
      logic [31:0] o;
      while (eq.size() > 0) begin
         t = tq.pop_front();
         s = sq.pop_front();
         e = eq.pop_front();
         o = obs(s);
         n_cmp++;
         assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", t, o, e);
         end
      end
   endtask

   // One clock cycle: queue stall and stall-count checks, sample at negedge, advance.
   task automatic cyc(input logic exp_stall, input string tag);
      push({tag, ":stall"}, SEL_STALL, {31'd0, exp_stall});
      push({tag, ":stall_cnt"}, SEL_SCNT, 32'(exp_sc));
      @(negedge i_clk);
      drain();
      if (exp_stall) exp_sc++;
      @(posedge i_clk);
      #1;
   endtask

   task automatic clr_in();
      i_idu_valid = 1'b0; i_idu_fire = 1'b0; i_idu_rs1id = 5'd0; i_idu_rs2id = 5'd0;
      i_idu_rdid = 5'd0; i_idu_rdwen = 1'b0; i_idu_lden = 1'b0; i_ld_ret = 1'b0;
      i_ld_retid = 5'd0; i_redirect = 1'b0; i_ifu_fire = 1'b0;
   endtask

   task automatic ld(input logic [4:0] rd, input logic fire);
      i_idu_valid = 1'b1; i_idu_fire = fire; i_idu_lden = 1'b1;
      i_idu_rdwen = 1'b1; i_idu_rdid = rd;
   endtask

   initial begin
      i_rst_n = 1'b0;
      clr_in();
      #2;
      push("rst:stall", SEL_STALL, 32'd0);
      push("rst:nop", SEL_NOP, 32'd0);
      push("rst:full", SEL_FULL, 32'd0);
      push("rst:pend", SEL_PEND, 32'd0);
      push("rst:scnt", SEL_SCNT, 32'd0);
      drain();
      #10 i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      // Load-use RAW on x5, released by same-cycle return
      ld(5'd5, 1'b1); push("A1:pend", SEL_PEND, 32'd0); cyc(1'b0, "A1");
      clr_in(); i_idu_valid = 1'b1; i_idu_rs1id = 5'd5; i_idu_rs2id = 5'd6;
      i_idu_rdid = 5'd8; i_idu_rdwen = 1'b1;
      push("A2:pend", SEL_PEND, 32'h20); cyc(1'b1, "A2");
      cyc(1'b1, "A3");
      i_ld_ret = 1'b1; i_ld_retid = 5'd5; i_idu_fire = 1'b1;
      push("A4:pend", SEL_PEND, 32'h20); cyc(1'b0, "A4");
      clr_in(); push("A5:pend", SEL_PEND, 32'd0); push("A5:full", SEL_FULL, 32'd0); cyc(1'b0, "A5");

      // x0 load and ALU writes never touch the scoreboard
      ld(5'd0, 1'b1); cyc(1'b0, "B1");
      clr_in(); i_idu_valid = 1'b1; i_ld_ret = 1'b1; i_ld_retid = 5'd0;
      push("B2:pend", SEL_PEND, 32'd0); cyc(1'b0, "B2");
      clr_in(); i_idu_valid = 1'b1; i_idu_fire = 1'b1; i_idu_rdwen = 1'b1; i_idu_rdid = 5'd7;
      cyc(1'b0, "B3");
      clr_in(); i_idu_valid = 1'b1; i_idu_rs1id = 5'd7;
      push("B4:pend", SEL_PEND, 32'd0); cyc(1'b0, "B4");

      // WAW on x3; return and reissue in the same cycle keeps the bit set
      clr_in(); ld(5'd3, 1'b1); cyc(1'b0, "C1");
      clr_in(); ld(5'd3, 1'b0); push("C2:pend", SEL_PEND, 32'h8); cyc(1'b1, "C2");
      i_ld_ret = 1'b1; i_ld_retid = 5'd3; i_idu_fire = 1'b1;
      push("C3:pend", SEL_PEND, 32'h8); cyc(1'b0, "C3");
      clr_in(); push("C4:pend", SEL_PEND, 32'h8); cyc(1'b0, "C4");
      clr_in(); i_ld_ret = 1'b1; i_ld_retid = 5'd3; cyc(1'b0, "C5");
      clr_in(); push("C6:pend", SEL_PEND, 32'd0); push("C6:full", SEL_FULL, 32'd0); cyc(1'b0, "C6");

      // Fill to MAX_LD, stall the fifth load, release it with a return
      for (int i = 1; i <= 4; i++) begin
         clr_in(); ld(5'(i), 1'b1);
         push($sformatf("D%0d:full", i), SEL_FULL, 32'd0);
         cyc(1'b0, $sformatf("D%0d", i));
      end
      clr_in(); ld(5'd9, 1'b0);
      push("D5:full", SEL_FULL, 32'd1); push("D5:pend", SEL_PEND, 32'h1E); cyc(1'b1, "D5");
      i_ld_ret = 1'b1; i_ld_retid = 5'd1; i_idu_fire = 1'b1;
      push("D6:full", SEL_FULL, 32'd1); cyc(1'b0, "D6");
      clr_in(); i_ld_ret = 1'b1; i_ld_retid = 5'd2;
      push("D7:full", SEL_FULL, 32'd1); push("D7:pend", SEL_PEND, 32'h21C); cyc(1'b0, "D7");
      clr_in(); push("D8:full", SEL_FULL, 32'd0); push("D8:pend", SEL_PEND, 32'h218); cyc(1'b0, "D8");

      // Redirect with two squash slots, fires two and five cycles later
      i_redirect = 1'b1; push("E1r:nop", SEL_NOP, 32'd0); cyc(1'b0, "E1r");
      clr_in(); push("E1a:nop", SEL_NOP, 32'd1); cyc(1'b0, "E1a");
      i_ifu_fire = 1'b1; push("E1b:nop", SEL_NOP, 32'd1); cyc(1'b0, "E1b");
      clr_in(); push("E1c:nop", SEL_NOP, 32'd1); cyc(1'b0, "E1c");
      push("E1d:nop", SEL_NOP, 32'd1); cyc(1'b0, "E1d");
      i_ifu_fire = 1'b1; push("E1e:nop", SEL_NOP, 32'd1); cyc(1'b0, "E1e");
      clr_in(); push("E1f:nop", SEL_NOP, 32'd0); cyc(1'b0, "E1f");

      // Redirect during squash, same cycle as a fire, reloads the count
      i_redirect = 1'b1; push("E2r:nop", SEL_NOP, 32'd0); cyc(1'b0, "E2r");
      clr_in(); push("E2a:nop", SEL_NOP, 32'd1); cyc(1'b0, "E2a");
      i_ifu_fire = 1'b1; push("E2b:nop", SEL_NOP, 32'd1); cyc(1'b0, "E2b");
      i_redirect = 1'b1; push("E2c:nop", SEL_NOP, 32'd1); cyc(1'b0, "E2c");
      clr_in();
      for (int i = 0; i < 5; i++) begin
         push($sformatf("E2hold%0d:nop", i), SEL_NOP, 32'd1); cyc(1'b0, "E2hold");
      end
      i_ifu_fire = 1'b1; push("E2d:nop", SEL_NOP, 32'd1); cyc(1'b0, "E2d");
      push("E2e:nop", SEL_NOP, 32'd1); cyc(1'b0, "E2e");
      push("E2f:nop", SEL_NOP, 32'd0); cyc(1'b0, "E2f");
      clr_in(); push("E2g:nop", SEL_NOP, 32'd0); cyc(1'b0, "E2g");

      // Async reset mid-squash with three loads pending
      i_redirect = 1'b1; cyc(1'b0, "F0");
      clr_in(); i_idu_valid = 1'b1; i_idu_rs1id = 5'd3;
      push("F1:nop", SEL_NOP, 32'd1); push("F1:pend", SEL_PEND, 32'h218); cyc(1'b1, "F1");
      #2;
      i_rst_n = 1'b0;
      #1;
      exp_sc = 0;
      push("Frst:stall", SEL_STALL, 32'd0);
      push("Frst:nop", SEL_NOP, 32'd0);
      push("Frst:full", SEL_FULL, 32'd0);
      push("Frst:pend", SEL_PEND, 32'd0);
      push("Frst:scnt", SEL_SCNT, 32'd0);
      drain();
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      clr_in();
      @(posedge i_clk);
      #1;
      ld(5'd10, 1'b1); push("F2:full", SEL_FULL, 32'd0); cyc(1'b0, "F2");
      clr_in();
      push("F3:full", SEL_FULL, 32'd0); push("F3:pend", SEL_PEND, 32'h400);
      push("F3:nop", SEL_NOP, 32'd0); cyc(1'b0, "F3");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
